// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist : built-in self-test driver for the ALU.
//
// Drives pseudo-random operand/opcode vectors into a combinational ALU,
// compresses each response (result plus flags) into a 32-bit MISR and, at the
// end of a run, compares the signature against a build-time golden value.
//
// Optional feature macro: ALU_BIST_CHECK_EN
//   defined   : an embedded reference ALU checks every response and
//               first_fail records the index of the first bad vector.
//   undefined : no reference model; first_fail stays 16'hFFFF.
//
// Ports:
//   CLK, RST     clock (rising edge), synchronous active-high reset
//   start        request to begin a run (honoured only when idle)
//   busy         high while vectors are being applied
//   done         one-cycle pulse at the end of a run
//   pass         result of the last completed run
//   signature    current MISR value
//   first_fail   index of the first mismatching vector, 16'hFFFF if none
//   aluOp        opcode driven to the ALU
//   port_a       operand A driven to the ALU
//   port_b       operand B driven to the ALU
//   port_out     ALU result
//   negative, overflow, zero   ALU flags
// -----------------------------------------------------------------------------
package alu_bist_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN      = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [15:0] first_fail,
  output aluop_t      aluOp,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  input  logic [31:0] port_out,
  input  logic        negative,
  input  logic        overflow,
  input  logic        zero
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [16:0] NUM_V     = 17'(NUM_VECTORS);
  localparam logic [15:0] NO_FAIL   = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state, state_next;
  logic [31:0] lfsr;
  logic [15:0] count;
  logic [3:0]  op_idx;
  logic        more;
  logic        ovf_m;
  logic [31:0] sig_next;
  logic [15:0] ff_next;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [31:0] derive_b(input logic [31:0] s);
    return {s[18:0], s[31:19]} ^ 32'h5A5A_5A5A;
  endfunction

  // count holds the number of vectors driven so far, so the vector currently
  // on the ALU inputs has index count-1.
  assign more = ({1'b0, count} < NUM_V);

  // MISR next value; overflow is meaningless for non-arithmetic ops, so it is
  // masked out to keep the signature independent of ALU don't-care behaviour.
  always_comb begin
    ovf_m    = ((aluOp == ALU_ADD) || (aluOp == ALU_SUB)) ? overflow : 1'b0;
    sig_next = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0)
               ^ port_out ^ {29'b0, negative, ovf_m, zero};
  end

`ifdef ALU_BIST_CHECK_EN
  logic [31:0] exp_out;
  logic        exp_ovf;
  logic        chk_ovf;
  logic        mismatch;

  // Reference ALU for the vector currently driven; first_fail only latches
  // the first bad index and is never overwritten afterwards.
  always_comb begin
    exp_out = 32'h0;
    exp_ovf = 1'b0;
    chk_ovf = 1'b0;
    case (aluOp)
      ALU_SLL:  exp_out = port_a << port_b[4:0];
      ALU_SRL:  exp_out = port_a >> port_b[4:0];
      ALU_ADD: begin
        exp_out = port_a + port_b;
        exp_ovf = (port_a[31] == port_b[31]) && (exp_out[31] != port_a[31]);
        chk_ovf = 1'b1;
      end
      ALU_SUB: begin
        exp_out = port_a - port_b;
        exp_ovf = (port_a[31] != port_b[31]) && (exp_out[31] != port_a[31]);
        chk_ovf = 1'b1;
      end
      ALU_AND:  exp_out = port_a & port_b;
      ALU_OR:   exp_out = port_a | port_b;
      ALU_XOR:  exp_out = port_a ^ port_b;
      ALU_NOR:  exp_out = ~(port_a | port_b);
      ALU_SLT:  exp_out = {31'b0, ($signed(port_a) < $signed(port_b))};
      ALU_SLTU: exp_out = {31'b0, (port_a < port_b)};
      default:  exp_out = 32'h0;
    endcase
    mismatch = (port_out != exp_out)
               || (negative != exp_out[31])
               || (zero != (exp_out == 32'h0))
               || (chk_ovf && (overflow != exp_ovf));
    ff_next  = ((first_fail == NO_FAIL) && mismatch) ? (count - 16'd1) : first_fail;
  end
`else
  assign ff_next = first_fail;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a run is IDLE -> RUN (NUM_VECTORS cycles) -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (!more) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Vector generation, response compression and result reporting. Every
  // output is registered; a vector driven on one edge is compressed on the
  // next, since the ALU in between is purely combinational.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= 32'h0;
      first_fail <= NO_FAIL;
      aluOp      <= ALU_SLL;
      port_a     <= 32'h0;
      port_b     <= 32'h0;
      lfsr       <= SEED;
      count      <= 16'd0;
      op_idx     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            pass       <= 1'b0;
            signature  <= 32'h0;
            first_fail <= NO_FAIL;
            aluOp      <= ALU_SLL;
            port_a     <= SEED;
            port_b     <= derive_b(SEED);
            lfsr       <= lfsr_step(SEED);
            count      <= 16'd1;
            op_idx     <= 4'd1;
          end
        end
        ST_RUN: begin
          signature  <= sig_next;
          first_fail <= ff_next;
          if (more) begin
            aluOp  <= aluop_t'(op_idx);
            port_a <= lfsr;
            port_b <= derive_b(lfsr);
            lfsr   <= lfsr_step(lfsr);
            count  <= count + 16'd1;
            op_idx <= (op_idx == 4'd9) ? 4'd0 : (op_idx + 4'd1);
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (sig_next == GOLDEN) && (ff_next == NO_FAIL);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// -----------------------------------------------------------------------------
// tb_alu_bist : self-checking bench for alu_bist.
//
// A behavioural ALU sits on the far side of the BIST and can be made healthy,
// stuck at zero, or corrupted on one chosen vector. A run-level model derives
// the vector stream, the final signature and the first failing index from
// plain arithmetic, and every DUT observation is compared against it.
// -----------------------------------------------------------------------------
module tb_alu_bist;
  import alu_bist_pkg::*;

  localparam int          N         = 12;
  localparam logic [31:0] SEED      = 32'hACE1_2468;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  // Next LFSR state: shift right, fold the mask in when a one falls out.
  function automatic logic [31:0] next_state(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Operand B is operand A rotated left by 13, then scrambled.
  function automatic logic [31:0] operand_b(input logic [31:0] x);
    return ((x << 13) | (x >> 19)) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic aluop_t op_at(input int i);
    case (i % 10)
      0: return ALU_SLL;
      1: return ALU_SRL;
      2: return ALU_ADD;
      3: return ALU_SUB;
      4: return ALU_AND;
      5: return ALU_OR;
      6: return ALU_XOR;
      7: return ALU_NOR;
      8: return ALU_SLT;
      default: return ALU_SLTU;
    endcase
  endfunction

  // Behavioural ALU. mode 0 healthy, 1 stuck at zero with flags low,
  // 2 flips result bit 0 when hit. junk is the don't-care overflow value
  // reported for non-arithmetic ops. Returns {result, negative, overflow, zero}.
  function automatic logic [34:0] alu_resp(input aluop_t op, input logic [31:0] a,
                                           input logic [31:0] b, input int mode,
                                           input logic hit, input logic junk);
    logic [31:0] r;
    logic        ovf;
    longint      s;
    r   = 32'h0;
    ovf = junk;
    s   = 0;
    case (op)
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_ADD: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        r   = a + b;
        ovf = (s != longint'($signed(r)));
      end
      ALU_SUB: begin
        s   = longint'($signed(a)) - longint'($signed(b));
        r   = a - b;
        ovf = (s != longint'($signed(r)));
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = 32'h0;
    endcase
    if (mode == 2 && hit) r = r ^ 32'h1;
    if (mode == 1) return 35'h0;
    return {r, r[31], ovf, (r == 32'h0)};
  endfunction

  // Signature of a whole run for a given ALU behaviour.
  function automatic logic [31:0] model_sig(input int mode, input int k, input logic junk);
    logic [31:0] x, sig;
    logic [34:0] resp;
    logic        ovf_m;
    aluop_t      op;
    x   = SEED;
    sig = 32'h0;
    for (int i = 0; i < N; i++) begin
      op    = op_at(i);
      resp  = alu_resp(op, x, operand_b(x), mode, (i == k), junk);
      ovf_m = (op == ALU_ADD || op == ALU_SUB) ? resp[1] : 1'b0;
      sig   = (sig << 1) ^ (sig[31] ? MISR_POLY : 32'h0) ^ resp[34:3]
              ^ {29'b0, resp[2], ovf_m, resp[0]};
      x     = next_state(x);
    end
    return sig;
  endfunction

  localparam logic [31:0] GOLDEN_V = model_sig(0, 0, 1'b0);

  logic        CLK, RST, start;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [15:0] first_fail;
  aluop_t      aluOp;
  logic [31:0] port_a, port_b, port_out;
  logic        negative, overflow, zero;

  int          fault_mode;
  logic [31:0] fault_key;
  logic        junk_ovf;
  logic [34:0] resp;

  logic [31:0] exp_a [N];
  logic [31:0] exp_b [N];
  aluop_t      exp_op [N];

  int vector_count;
  int miscompare_count;

  alu_bist #(
    .NUM_VECTORS(N),
    .SEED       (SEED),
    .GOLDEN     (GOLDEN_V)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .first_fail(first_fail),
    .aluOp     (aluOp),
    .port_a    (port_a),
    .port_b    (port_b),
    .port_out  (port_out),
    .negative  (negative),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The ALU under screen, driven straight from the BIST outputs.
  always_comb begin
    resp = alu_resp(aluOp, port_a, port_b, fault_mode, (port_a == fault_key), junk_ovf);
    {port_out, negative, overflow, zero} = resp;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vector_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One complete run from IDLE: vector stream, busy/done timing, results.
  // poke re-pulses start mid-run, which must have no effect.
  task automatic applyStimulus(input int mode, input int k, input logic junk, input logic poke);
    logic [31:0] exp_sig;
    logic [15:0] exp_ff;
    logic        exp_pass;
    fault_mode = mode;
    fault_key  = exp_a[k];
    junk_ovf   = junk;
    exp_sig    = model_sig(mode, k, junk);
`ifdef ALU_BIST_CHECK_EN
    exp_ff = (mode == 0) ? 16'hFFFF : (mode == 1) ? 16'd0 : 16'(k);
`else
    exp_ff = 16'hFFFF;
`endif
    exp_pass = (exp_sig == GOLDEN_V) && (exp_ff == 16'hFFFF);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      checkOutput("run.aluOp", 64'(aluOp), 64'(exp_op[i]));
      checkOutput("run.port_a", 64'(port_a), 64'(exp_a[i]));
      checkOutput("run.port_b", 64'(port_b), 64'(exp_b[i]));
      checkOutput("run.busy", 64'(busy), 64'd1);
      checkOutput("run.done", 64'(done), 64'd0);
      if (poke && i == 1) start = 1'b1;
      if (poke && i == 2) start = 1'b0;
      step();
    end
    checkOutput("end.done", 64'(done), 64'd1);
    checkOutput("end.busy", 64'(busy), 64'd0);
    checkOutput("end.signature", 64'(signature), 64'(exp_sig));
    checkOutput("end.first_fail", 64'(first_fail), 64'(exp_ff));
    checkOutput("end.pass", 64'(pass), 64'(exp_pass));
    checkOutput("end.hold_a", 64'(port_a), 64'(exp_a[N-1]));
    step();
    checkOutput("after.done", 64'(done), 64'd0);
    checkOutput("after.signature", 64'(signature), 64'(exp_sig));
    checkOutput("after.pass", 64'(pass), 64'(exp_pass));
  endtask

  initial begin
    logic [31:0] x;
    int          done_seen;
    vector_count     = 0;
    miscompare_count = 0;
    fault_mode       = 0;
    fault_key        = 32'h0;
    junk_ovf         = 1'b0;
    start            = 1'b0;
    RST              = 1'b1;

    x = SEED;
    for (int i = 0; i < N; i++) begin
      exp_a[i]  = x;
      exp_b[i]  = operand_b(x);
      exp_op[i] = op_at(i);
      x         = next_state(x);
    end

    // Reset state.
    repeat (2) step();
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.pass", 64'(pass), 64'd0);
    checkOutput("rst.signature", 64'(signature), 64'd0);
    checkOutput("rst.first_fail", 64'(first_fail), 64'hFFFF);
    checkOutput("rst.aluOp", 64'(aluOp), 64'(ALU_SLL));
    checkOutput("rst.port_a", 64'(port_a), 64'd0);
    RST = 1'b0;
    step();

    // Healthy ALU, twice: pass and repeatable signature; then with a
    // start pulse dropped in mid-run.
    checkOutput("seed.port_a", 64'(exp_a[0]), 64'h0000_0000_ACE1_2468);
    applyStimulus(0, 0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1'b1, 1'b1);

    // Stuck-at-zero ALU.
    applyStimulus(1, 0, 1'b0, 1'b0);

    // Randomised ALU behaviour, fault position, flag junk and idle gaps.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) step();
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset during the third RUN cycle aborts without a done pulse.
    fault_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.signature", 64'(signature), 64'd0);
    checkOutput("abort.first_fail", 64'(first_fail), 64'hFFFF);
    checkOutput("abort.aluOp", 64'(aluOp), 64'(ALU_SLL));
    checkOutput("abort.port_a", 64'(port_a), 64'd0);
    done_seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      if (done) done_seen++;
      step();
    end
    checkOutput("abort.no_done", 64'(done_seen), 64'd0);
    applyStimulus(0, 0, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    RST   = 1'b1;
    start = 1'b1;
    step();
    RST   = 1'b0;
    start = 1'b0;
    checkOutput("rst_prio.busy", 64'(busy), 64'd0);
    step();
    checkOutput("rst_prio.idle", 64'(busy), 64'd0);

    // start held through DONE relaunches on the first IDLE cycle.
    start = 1'b1;
    repeat (N + 1) step();
    checkOutput("held.done", 64'(done), 64'd1);
    step();
    checkOutput("held.idle_busy", 64'(busy), 64'd0);
    checkOutput("held.idle_done", 64'(done), 64'd0);
    step();
    start = 1'b0;
    checkOutput("held.restart_busy", 64'(busy), 64'd1);
    checkOutput("held.restart_a", 64'(port_a), 64'(exp_a[0]));
    checkOutput("held.restart_op", 64'(aluOp), 64'(ALU_SLL));
    repeat (N) step();
    checkOutput("held.done2", 64'(done), 64'd1);
    checkOutput("held.pass2", 64'(pass), 64'd1);
    checkOutput("held.sig2", 64'(signature), 64'(GOLDEN_V));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
